// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan code set 2 constants, frame FSM states and the parity helper.
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_F     = 8'h2B;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } frame_state_t;

   // Odd parity: data plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM and timeout.
// Parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error,
   output logic       frame_timeout
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]     clk_sync, data_sync;
   logic           clk_s, data_s;
   logic           filt_clk, filt_flip, strobe;
   logic [FCW-1:0] filt_cnt;

   frame_state_t   state, state_n;
   logic [2:0]     bit_cnt, bit_cnt_n;
   logic [7:0]     shift_reg, shift_n;
   logic           parity_bit, parity_n, parity_ok;
   logic [TCW-1:0] to_cnt, to_cnt_n;

   // Synchronizers idle high, matching an undriven PS/2 bus.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
   assign filt_flip = (clk_s != filt_clk) && (filt_cnt == FCW'(FILTER_LEN - 1));
   assign strobe    = filt_flip && filt_clk;

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_flip) begin
         filt_clk <= clk_s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FCW'(1);
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = odd_parity_ok(shift_reg, parity_bit);
`else
   // Parity bit is still captured but never gates acceptance.
   assign parity_ok = odd_parity_ok(shift_reg, parity_bit) | 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         to_cnt     <= '0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift_reg  <= shift_n;
         parity_bit <= parity_n;
         to_cnt     <= to_cnt_n;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves a latch.
      state_n       = state;
      bit_cnt_n     = bit_cnt;
      shift_n       = shift_reg;
      parity_n      = parity_bit;
      to_cnt_n      = (state == IDLE || strobe) ? '0 : to_cnt + TCW'(1);
      byte_valid    = 1'b0;
      frame_error   = 1'b0;
      frame_timeout = 1'b0;

      if (state != IDLE && to_cnt == TCW'(TIMEOUT_CYCLES)) begin
         state_n       = IDLE;
         to_cnt_n      = '0;
         frame_error   = 1'b1;
         frame_timeout = 1'b1;
      end else if (strobe) begin
         case (state)
            IDLE: begin
               if (!data_s) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end else begin
                  frame_error = 1'b1;
               end
            end
            DATA: begin
               shift_n   = {data_s, shift_reg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               parity_n = data_s;
               state_n  = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (data_s && parity_ok) byte_valid  = 1'b1;
               else                     frame_error = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign rx_byte = shift_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: make/break/extended prefix tracking into one-cycle game key pulses.
// Parity enforcement in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       upPressed,
   output logic       downPressed,
   output logic       leftPressed,
   output logic       rightPressed,
   output logic       enterPressed,
   output logic       fPressed,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_error
);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_error, rx_timeout;
   logic       ext, brk;

   ps2_rx_frame #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk           (clk),
      .reset         (reset),
      .ps2_clk       (ps2_clk),
      .ps2_data      (ps2_data),
      .rx_byte       (rx_byte),
      .byte_valid    (rx_valid),
      .frame_error   (rx_error),
      .frame_timeout (rx_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         upPressed    <= 1'b0;
         downPressed  <= 1'b0;
         leftPressed  <= 1'b0;
         rightPressed <= 1'b0;
         enterPressed <= 1'b0;
         fPressed     <= 1'b0;
         code         <= '0;
         code_valid   <= 1'b0;
         frame_error  <= 1'b0;
         ext          <= 1'b0;
         brk          <= 1'b0;
      end else begin
         upPressed    <= 1'b0;
         downPressed  <= 1'b0;
         leftPressed  <= 1'b0;
         rightPressed <= 1'b0;
         enterPressed <= 1'b0;
         fPressed     <= 1'b0;
         code_valid   <= 1'b0;
         frame_error  <= rx_error;

         // Only a timeout drops pending prefixes; other bad frames leave them intact.
         if (rx_timeout) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end

         if (rx_valid) begin
            code       <= rx_byte;
            code_valid <= 1'b1;
            if (rx_byte == SC_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == SC_BREAK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (!brk && ext) begin
                  case (rx_byte)
                     SC_UP:    upPressed    <= 1'b1;
                     SC_DOWN:  downPressed  <= 1'b1;
                     SC_LEFT:  leftPressed  <= 1'b1;
                     SC_RIGHT: rightPressed <= 1'b1;
                     default:  ;
                  endcase
               end else if (!brk) begin
                  case (rx_byte)
                     SC_ENTER: enterPressed <= 1'b1;
                     SC_F:     fPressed     <= 1'b1;
                     default:  ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a scoreboard of expected output events checked by a negedge monitor.
module tb_ps2_key_decoder;
   import ps2_pkg::*;

   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;
   localparam int HALF       = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       upPressed, downPressed, leftPressed, rightPressed, enterPressed, fPressed;
   logic [7:0] code;
   logic       code_valid, frame_error;
   logic [5:0] keys;

   typedef struct packed {
      logic       cv;
      logic [7:0] code;
      logic       fe;
      logic [5:0] keys;
   } ev_t;

   ev_t        exp_q[$];
   int         compared   = 0;
   int         mismatched = 0;
   logic       m_ext = 1'b0;
   logic       m_brk = 1'b0;
   logic [7:0] m_code = 8'h00;

   ps2_key_decoder #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .upPressed    (upPressed),
      .downPressed  (downPressed),
      .leftPressed  (leftPressed),
      .rightPressed (rightPressed),
      .enterPressed (enterPressed),
      .fPressed     (fPressed),
      .code         (code),
      .code_valid   (code_valid),
      .frame_error  (frame_error)
   );

   assign keys = {upPressed, downPressed, leftPressed, rightPressed, enterPressed, fPressed};

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Monitor: every cycle with any output activity must match the next scoreboard entry.
   always @(negedge clk) begin
      ev_t obs_ev, exp_ev;
      if (!reset && (code_valid || frame_error || (|keys))) begin
         obs_ev = {code_valid, code, frame_error, keys};
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(obs_ev), 32'h0);
         end else begin
            exp_ev = exp_q.pop_front();
            check("output_event", 32'(obs_ev), 32'(exp_ev));
         end
      end
   end

   task automatic push_event(input logic cv, input logic [7:0] c, input logic fe, input logic [5:0] k);
      ev_t e;
      e.cv   = cv;
      e.code = c;
      e.fe   = fe;
      e.keys = k;
      exp_q.push_back(e);
   endtask

   // Reference decode of one accepted byte; key order is {up,down,left,right,enter,f}.
   task automatic expect_good(input logic [7:0] b);
      logic [5:0] k;
      k = 6'b0;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (!m_brk && m_ext) begin
            if (b == 8'h75) k = 6'b100000;
            if (b == 8'h72) k = 6'b010000;
            if (b == 8'h6B) k = 6'b001000;
            if (b == 8'h74) k = 6'b000100;
         end else if (!m_brk) begin
            if (b == 8'h5A) k = 6'b000010;
            if (b == 8'h2B) k = 6'b000001;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      m_code = b;
      push_event(1'b1, b, 1'b0, k);
   endtask

   task automatic expect_error();
      push_event(1'b0, m_code, 1'b1, 6'b0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic d);
      @(negedge clk);
      ps2_data = d;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic glitch();
      wait_cycles(8);
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // Full 11-bit frame; glitch_after >= 0 injects a 1-cycle clock glitch after that bit.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int glitch_after);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_bit(bits[i]);
         if (i == glitch_after) glitch();
      end
      wait_cycles(30);
   endtask

   task automatic drained(input string tag);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic send_good(input logic [7:0] b);
      expect_good(b);
      send_frame(b, 1'b0, 1'b1, -1);
      drained("drain_good");
   endtask

   initial begin
      wait_cycles(5);
      check("reset_code", 32'(code), 32'h00);
      check("reset_pulses", 32'({code_valid, frame_error, keys}), 32'h0);
      reset = 1'b0;
      wait_cycles(10);
      check("post_reset_outputs", 32'({code, code_valid, frame_error, keys}), 32'h0);

      // Enter, extended up, released up, keypad arrow, F.
      send_good(8'h5A);
      send_good(8'hE0);
      send_good(8'h75);
      send_good(8'hE0);
      send_good(8'hF0);
      send_good(8'h75);
      send_good(8'h75);
      send_good(8'h2B);
      send_good(8'h2B);

      // Parity forced wrong on F.
`ifdef PS2_PARITY_CHECK_EN
      expect_error();
`else
      expect_good(8'h2B);
`endif
      send_frame(8'h2B, 1'b1, 1'b1, -1);
      drained("drain_parity");

      // Bad stop bit keeps a pending E0.
      send_good(8'hE0);
      expect_error();
      send_frame(8'h75, 1'b0, 1'b0, -1);
      drained("drain_bad_stop");
      send_good(8'h75);

      // Bad start bit: lone falling edge with data high.
      expect_error();
      ps2_bit(1'b1);
      wait_cycles(30);
      drained("drain_bad_start");

      // Timeout after 5 data bits drops the pending E0.
      send_good(8'hE0);
      expect_error();
      m_ext = 1'b0;
      m_brk = 1'b0;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(i[0]);
      wait_cycles(TIMEOUT + 100);
      drained("drain_timeout");
      send_good(8'h75);
      send_good(8'hE0);
      send_good(8'h6B);

      // One-cycle glitch between data bits must not shift a bit.
      send_good(8'hE0);
      expect_good(8'h74);
      send_frame(8'h74, 1'b0, 1'b1, 3);
      drained("drain_glitch");
      send_good(8'hE0);
      send_good(8'h72);

      // Reset during bit 4 abandons the frame and the pending E0.
      send_good(8'hE0);
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      @(negedge clk);
      reset = 1'b1;
      wait_cycles(5);
      check("mid_reset_outputs", 32'({code, code_valid, frame_error, keys}), 32'h0);
      reset = 1'b0;
      m_code = 8'h00;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      wait_cycles(TIMEOUT + 50);
      check("after_reset_outputs", 32'({code, code_valid, frame_error, keys}), 32'h0);
      drained("drain_reset");
      send_good(8'h75);
      send_good(8'h5A);

      wait_cycles(50);
      drained("final_drain");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames (scan code set 2), decodes make, break and extended prefixes, and emits one-cycle key pulses. Sits directly upstream of the minesweeper game controller and drives its upPressed, downPressed, leftPressed, rightPressed, enterPressed and fPressed inputs. Also exposes raw byte and error strobes for debug LEDs.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- ps2_clk  in  1  raw PS/2 clock from the pin, asynchronous.
- ps2_data  in  1  raw PS/2 data from the pin, asynchronous.
- upPressed, downPressed, leftPressed, rightPressed  out  1 each  one-cycle pulse per arrow make code.
- enterPressed, fPressed  out  1 each  one-cycle pulse per Enter / F make code.
- code  out  8  last accepted byte; holds its value until the next accepted byte.
- code_valid  out  1  one-cycle pulse when code updates.
- frame_error  out  1  one-cycle pulse on bad start, bad stop, parity failure (when checked) or timeout.

## Operation
- Input conditioning: 2-flop synchronizer on both pins. ps2_clk passes through a level filter of FILTER_LEN samples. A falling edge of the filtered clock is the sample strobe. ps2_data is taken from its synchronizer output at the strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with data=0 (start bit), go to DATA with bit count 0. On a strobe with data=1, stay in IDLE and pulse frame_error.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: if data=1 and parity is good, accept the byte. Otherwise pulse frame_error and discard the byte. Return to IDLE in both cases.
- Parity is odd: the 8 data bits plus the parity bit contain an odd number of ones.
- Byte decoder holds two flags, ext and brk, both cleared at reset:
  - E0: set ext.
  - F0: set brk.
  - Any other byte: if brk=0, pulse the output that matches (ext, byte), then clear both flags. If brk=1, emit no pulse and clear both flags.
- Code map:
  - ext=1: 75 up, 72 down, 6B left, 74 right.
  - ext=0: 5A enter, 2B F.
  - Every other combination, including non-extended 75/72/6B/74 (keypad arrows), produces no pulse.
- Typematic repeats are repeated make codes, and each one produces a pulse. This gives auto-repeat cursor movement.
- At most one key output is high in any cycle.
- code and code_valid update on every accepted byte, including E0, F0 and unmapped codes.

## Timing
- Reset values: all pulse outputs 0, code=00, FSM in IDLE, ext=brk=0, filtered clock=1, timeout counter=0, synchronizers=1.
- Latency:
  - Raw pin edge to strobe: 2 synchronizer cycles plus FILTER_LEN cycles.
  - Stop-bit strobe at cycle N: code_valid, the key pulse and frame_error (if any) are all high in cycle N+1 only.
- Timeout:
  - The counter clears on every strobe and while in IDLE.
  - In any non-IDLE state, when it reaches TIMEOUT_CYCLES the FSM returns to IDLE, frame_error pulses, and ext and brk clear.
- A bad frame leaves ext and brk unchanged.
- Reset asserted mid-frame abandons the frame immediately and produces no pulses.
- Output pulses are not held or queued. The controller samples them in its hub state. PS/2 byte spacing (>1 ms) far exceeds controller non-hub dwell, so no handshake is needed.

## Configuration
- PS2_PARITY_CHECK_EN:
  - Defined: a parity mismatch discards the byte and pulses frame_error.
  - Undefined: the parity bit is captured but ignored, and only the start, stop and timeout checks apply.

## Structure
- Shared package ps2_pkg holds:
  - Scan code constants: SC_EXT=E0, SC_BREAK=F0, SC_UP=75, SC_DOWN=72, SC_LEFT=6B, SC_RIGHT=74, SC_ENTER=5A, SC_F=2B.
  - The frame FSM state enum.
- Sub-module ps2_rx_frame covers synchronizer, filter, frame FSM, parity and timeout. Its outputs are byte[7:0], byte_valid and frame_error.
- The top level keeps the ext/brk decoder and the pulse registers.

## Test plan
- Frame 5A with parity 1 and stop 1 -> enterPressed high exactly 1 cycle; code=5A; code_valid 1 cycle; frame_error low.
- Bytes E0, 75 -> exactly one upPressed pulse. Then E0, F0, 75 -> no pulse, with code_valid pulsed three times.
- Byte 75 without E0 -> no key pulse. Then 2B -> one fPressed pulse.
- Frame 2B with parity forced 0:
  - With PS2_PARITY_CHECK_EN defined: frame_error pulse, no fPressed, code unchanged.
  - Without it: fPressed pulses.
- 5 data bits followed by TIMEOUT_CYCLES idle cycles -> frame_error pulse, FSM back in IDLE. A following full 6B frame after an E0 -> leftPressed.
- 1-cycle glitch on ps2_clk with FILTER_LEN=4 -> no strobe and no bit shifted. Reset during bit 4 of a frame -> all outputs 0 and the next full frame decodes correctly.
